// File: rtl/sd_block_responder_pkg.sv
// Shared types and constants for the SD block responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sd_block_responder_pkg;

  localparam int BLOCK_BYTES = 512;
  localparam int OFS_W       = 9;
  localparam int LBA_W       = 32;
  localparam int DATA_W      = 8;
  localparam int STORE_AW    = LBA_W + OFS_W;

  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(BLOCK_BYTES - 1);

  // Block-level control states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_XFER_RD,
    ST_XFER_WR,
    ST_RELEASE
  } state_t;

  // Per-byte phases of the byte sequencer.
  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_RD_REQ,
    SQ_RD_STB,
    SQ_WR_ADDR,
    SQ_WR_CAP,
    SQ_WR_STORE
  } seq_phase_t;

  // Flat byte address into the backing image.
  function automatic logic [STORE_AW-1:0] store_byte_addr(
    input logic [LBA_W-1:0] lba,
    input logic [OFS_W-1:0] ofs
  );
    return {lba, ofs};
  endfunction

endpackage

// File: rtl/sd_block_responder_if.sv
// Initiator-side and backing-store-side signals of the SD block responder.
// Latency: none (wiring only).
// Backpressure: store side is held request / store_ready completion.
interface sd_block_responder_if;
  import sd_block_responder_pkg::*;

  logic [LBA_W-1:0]    sd_lba;
  logic                sd_rd;
  logic                sd_wr;
  logic                sd_ack;
  logic [OFS_W-1:0]    sd_buff_addr;
  logic [DATA_W-1:0]   sd_buff_dout;
  logic                sd_buff_wr;
  logic [DATA_W-1:0]   sd_buff_din;
  logic [STORE_AW-1:0] store_addr;
  logic                store_rd;
  logic                store_wr;
  logic [DATA_W-1:0]   store_wdata;
  logic [DATA_W-1:0]   store_rdata;
  logic                store_ready;
  logic                err_oob;

  // Responder view.
  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, store_rdata, store_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           store_addr, store_rd, store_wr, store_wdata, err_oob
  );

  // Initiator + backing-store view.
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, store_rdata, store_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           store_addr, store_rd, store_wr, store_wdata, err_oob
  );

endinterface

// File: rtl/sd_block_responder_byte_seq.sv
// Walks the 512 byte offsets of one block and runs the per-byte store handshake.
// Latency: read 2 cycles/byte + store wait; write 3 cycles/byte + store wait.
// Backpressure: store_rd/store_wr held until store_ready; out-of-range blocks bypass the store.
module sd_byte_sequencer
  import sd_block_responder_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_is_wr,
  input  logic                i_oob,
  input  logic [LBA_W-1:0]    i_lba,
  input  logic [DATA_W-1:0]   i_buff_din,
  input  logic [DATA_W-1:0]   i_store_rdata,
  input  logic                i_store_ready,
  output logic                o_done,
  output logic [OFS_W-1:0]    o_buff_addr,
  output logic [DATA_W-1:0]   o_buff_dout,
  output logic                o_buff_wr,
  output logic [STORE_AW-1:0] o_store_addr,
  output logic                o_store_rd,
  output logic                o_store_wr,
  output logic [DATA_W-1:0]   o_store_wdata
);

  seq_phase_t          r_phase;
  logic [OFS_W-1:0]    r_addr;
  logic [DATA_W-1:0]   r_buff_dout;
  logic                r_buff_wr;
  logic [STORE_AW-1:0] r_store_addr;
  logic                r_store_rd;
  logic                r_store_wr;
  logic [DATA_W-1:0]   r_store_wdata;
  logic                r_done;

  logic [OFS_W-1:0]    w_addr_nxt;
  logic                w_last;

  assign w_addr_nxt = r_addr + 9'd1;
  assign w_last     = (r_addr == OFS_LAST);

  // Byte phase machine: offset counter, store request/ready handshake, read strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase       <= SQ_IDLE;
      r_addr        <= '0;
      r_buff_dout   <= '0;
      r_buff_wr     <= 1'b0;
      r_store_addr  <= '0;
      r_store_rd    <= 1'b0;
      r_store_wr    <= 1'b0;
      r_store_wdata <= '0;
      r_done        <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_buff_wr <= 1'b0;
      case (r_phase)
        SQ_IDLE: begin
          if (i_start) begin
            r_addr <= '0;
            if (i_is_wr) begin
              r_phase <= SQ_WR_ADDR;
            end else begin
              r_phase <= SQ_RD_REQ;
              if (!i_oob) begin
                r_store_rd   <= 1'b1;
                r_store_addr <= store_byte_addr(i_lba, '0);
              end
            end
          end
        end
        SQ_RD_REQ: begin
          // Out-of-range reads return zeros without touching the store.
          if (i_oob) begin
            r_buff_dout <= '0;
            r_buff_wr   <= 1'b1;
            r_phase     <= SQ_RD_STB;
          end else if (r_store_rd && i_store_ready) begin
            r_store_rd  <= 1'b0;
            r_buff_dout <= i_store_rdata;
            r_buff_wr   <= 1'b1;
            r_phase     <= SQ_RD_STB;
          end
        end
        SQ_RD_STB: begin
          // Offset moves only after the strobe cycle, so it is stable under sd_buff_wr.
          if (w_last) begin
            r_done  <= 1'b1;
            r_phase <= SQ_IDLE;
          end else begin
            r_addr  <= w_addr_nxt;
            r_phase <= SQ_RD_REQ;
            if (!i_oob) begin
              r_store_rd   <= 1'b1;
              r_store_addr <= store_byte_addr(i_lba, w_addr_nxt);
            end
          end
        end
        SQ_WR_ADDR: begin
          // Initiator answers the presented offset one cycle later.
          r_phase <= SQ_WR_CAP;
        end
        SQ_WR_CAP: begin
          if (i_oob) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_phase <= SQ_IDLE;
            end else begin
              r_addr  <= w_addr_nxt;
              r_phase <= SQ_WR_ADDR;
            end
          end else begin
            r_store_wdata <= i_buff_din;
            r_store_addr  <= store_byte_addr(i_lba, r_addr);
            r_store_wr    <= 1'b1;
            r_phase       <= SQ_WR_STORE;
          end
        end
        SQ_WR_STORE: begin
          if (r_store_wr && i_store_ready) begin
            r_store_wr <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_phase <= SQ_IDLE;
            end else begin
              r_addr  <= w_addr_nxt;
              r_phase <= SQ_WR_ADDR;
            end
          end
        end
        default: r_phase <= SQ_IDLE;
      endcase
    end
  end

  assign o_done        = r_done;
  assign o_buff_addr   = r_addr;
  assign o_buff_dout   = r_buff_dout;
  assign o_buff_wr     = r_buff_wr;
  assign o_store_addr  = r_store_addr;
  assign o_store_rd    = r_store_rd;
  assign o_store_wr    = r_store_wr;
  assign o_store_wdata = r_store_wdata;

endmodule

// File: rtl/sd_block_responder.sv
// Serves SD block read/write requests from a byte-wide backing store.
// Latency: sd_ack rises ACK_DELAY cycles after capture; 512 bytes then 2-cycle release.
// Backpressure: per-byte store handshake stalls the transfer; requests only taken in IDLE.
module sd_block_responder
  import sd_block_responder_pkg::*;
#(
  parameter int unsigned ACK_DELAY  = 4,
  parameter int unsigned IMG_BLOCKS = 65536
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  sd_block_responder_if.slave  io_sd
);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [LBA_W-1:0]  r_lba;
  logic              r_is_wr;
  logic              r_oob;
  logic              r_sd_ack;
  logic              r_err_oob;

  logic              w_req_oob;
  logic              w_start;
  logic              w_seq_done;
  logic [OFS_W-1:0]  w_buff_addr;
  logic [DATA_W-1:0] w_buff_dout;
  logic              w_buff_wr;
  logic [STORE_AW-1:0] w_store_addr;
  logic              w_store_rd;
  logic              w_store_wr;
  logic [DATA_W-1:0] w_store_wdata;

  assign w_req_oob = (io_sd.sd_lba >= 32'(IMG_BLOCKS));
  assign w_start   = (r_state == ST_DELAY) && (r_cnt == 8'(ACK_DELAY - 1));

  // Block FSM: capture request, ack delay, transfer, two-step release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lba     <= '0;
      r_is_wr   <= 1'b0;
      r_oob     <= 1'b0;
      r_sd_ack  <= 1'b0;
      r_err_oob <= 1'b0;
    end else begin
      r_err_oob <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (io_sd.sd_rd || io_sd.sd_wr) begin
            r_lba     <= io_sd.sd_lba;
            r_is_wr   <= !io_sd.sd_rd;   // read wins when both are raised
            r_oob     <= w_req_oob;
            r_err_oob <= w_req_oob;      // visible during the first DELAY cycle
            r_cnt     <= '0;
            r_state   <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (w_start) begin
            r_sd_ack <= 1'b1;
            r_state  <= r_is_wr ? ST_XFER_WR : ST_XFER_RD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_XFER_RD, ST_XFER_WR: begin
          if (w_seq_done) r_state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // First cycle drops ack, second returns to IDLE.
          if (r_sd_ack) r_sd_ack <= 1'b0;
          else          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sd_byte_sequencer u_seq (
    .i_clk         (clk_sys),
    .i_rst_n       (reset_n),
    .i_start       (w_start),
    .i_is_wr       (r_is_wr),
    .i_oob         (r_oob),
    .i_lba         (r_lba),
    .i_buff_din    (io_sd.sd_buff_din),
    .i_store_rdata (io_sd.store_rdata),
    .i_store_ready (io_sd.store_ready),
    .o_done        (w_seq_done),
    .o_buff_addr   (w_buff_addr),
    .o_buff_dout   (w_buff_dout),
    .o_buff_wr     (w_buff_wr),
    .o_store_addr  (w_store_addr),
    .o_store_rd    (w_store_rd),
    .o_store_wr    (w_store_wr),
    .o_store_wdata (w_store_wdata)
  );

  assign io_sd.sd_ack       = r_sd_ack;
  assign io_sd.err_oob      = r_err_oob;
  assign io_sd.sd_buff_addr = w_buff_addr;
  assign io_sd.sd_buff_dout = w_buff_dout;
  assign io_sd.sd_buff_wr   = w_buff_wr;
  assign io_sd.store_addr   = w_store_addr;
  assign io_sd.store_rd     = w_store_rd;
  assign io_sd.store_wr     = w_store_wr;
  assign io_sd.store_wdata  = w_store_wdata;

endmodule

// File: tb/tb_sd_block_responder.sv
// Scoreboard bench for sd_block_responder: initiator, backing store model and monitors.
// Latency: expects sd_ack 5 cycles after a request with ACK_DELAY=4.
// Backpressure: store model can stall store_ready 0-7 cycles per access.
module tb_sd_block_responder;
  import sd_block_responder_pkg::*;

  localparam int T_ACK_DELAY  = 4;
  localparam int T_IMG_BLOCKS = 65536;

  typedef struct packed { logic [8:0]  addr; logic [7:0] data; } rd_exp_t;
  typedef struct packed { logic [40:0] addr; logic [7:0] data; } wr_exp_t;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  sd_block_responder_if bus();

  sd_block_responder #(.ACK_DELAY(T_ACK_DELAY), .IMG_BLOCKS(T_IMG_BLOCKS)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .io_sd   (bus)
  );

  int total = 0;
  int bad   = 0;
  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  int n_bwr, n_strd, n_stwr, n_err, n_dbl;
  int n_both  = 0;
  int n_unexp = 0;
  bit stall_en = 1'b0;
  bit prev_bwr = 1'b0;
  logic [8:0] addr_q = '0;
  bit busy = 1'b0;
  int stall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_bwr = 0; n_strd = 0; n_stwr = 0; n_err = 0; n_dbl = 0;
  endtask

  // Initiator write data: answers the offset shown in the previous cycle.
  always @(negedge clk_sys) addr_q = bus.sd_buff_addr;
  always @(posedge clk_sys) begin
    #1;
    bus.sd_buff_din = ~addr_q[7:0];
  end

  // Backing store: returns addr[7:0] on reads, optionally stalls each access.
  always @(posedge clk_sys) begin
    #1;
    if (!reset_n) begin
      bus.store_ready = 1'b0;
      bus.store_rdata = '0;
      busy = 1'b0;
    end else if (bus.store_ready) begin
      bus.store_ready = 1'b0;
    end else if (bus.store_rd || bus.store_wr) begin
      if (!busy) begin
        busy  = 1'b1;
        stall = stall_en ? int'($urandom_range(0, 7)) : 0;
      end
      if (stall == 0) begin
        bus.store_ready = 1'b1;
        bus.store_rdata = bus.store_addr[7:0];
        busy = 1'b0;
      end else begin
        stall--;
      end
    end
  end

  // Monitors: compare delivered bytes and store writes against the scoreboard.
  always @(negedge clk_sys) begin
    rd_exp_t re;
    wr_exp_t we;
    if (!reset_n) begin
      prev_bwr = 1'b0;
    end else begin
      if (bus.sd_buff_wr) begin
        n_bwr++;
        if (prev_bwr) n_dbl++;
        if (rd_q.size() == 0) n_unexp++;
        else begin
          re = rd_q.pop_front();
          chk("rd_byte", {bus.sd_buff_addr, bus.sd_buff_dout}, {re.addr, re.data});
        end
      end
      prev_bwr = bus.sd_buff_wr;
      if (bus.store_rd && bus.store_wr) n_both++;
      if (bus.err_oob) begin
        n_err++;
        if (dut.r_state != ST_DELAY) n_unexp++;
      end
      if (bus.store_ready && bus.store_rd) n_strd++;
      if (bus.store_ready && bus.store_wr) begin
        n_stwr++;
        if (wr_q.size() == 0) n_unexp++;
        else begin
          we = wr_q.pop_front();
          chk("st_wr", {bus.store_addr, bus.store_wdata}, {we.addr, we.data});
        end
      end
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"}, {bus.sd_ack, bus.sd_buff_wr, bus.store_rd, bus.store_wr, bus.err_oob}, 0);
    chk({tag, "_addr"}, bus.sd_buff_addr, 0);
    chk({tag, "_dout"}, bus.sd_buff_dout, 0);
    chk({tag, "_saddr"}, bus.store_addr, 0);
    chk({tag, "_wdata"}, bus.store_wdata, 0);
    chk({tag, "_state"}, dut.r_state, ST_IDLE);
  endtask

  task automatic wait_ack(input string tag);
    int cyc = 0;
    do begin
      @(posedge clk_sys); #1;
      cyc++;
    end while (!bus.sd_ack && cyc < 50);
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    chk({tag, "_ack_lat"}, cyc, T_ACK_DELAY + 1);
    chk({tag, "_ack_ofs"}, bus.sd_buff_addr, 0);
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic [31:0] lba, input string tag);
    int cyc = 0;
    @(posedge clk_sys); #1;
    bus.sd_lba = lba;
    bus.sd_rd  = rd;
    bus.sd_wr  = wr;
    wait_ack(tag);
    while (bus.sd_ack && cyc < 20000) begin
      @(posedge clk_sys); #1;
      cyc++;
    end
    chk({tag, "_ack_fall"}, bus.sd_ack, 0);
    @(posedge clk_sys); #1;
    chk({tag, "_idle"}, dut.r_state, ST_IDLE);
  endtask

  task automatic push_rd(input logic [31:0] lba, input bit zero);
    for (int i = 0; i < 512; i++)
      rd_q.push_back('{addr: 9'(i), data: zero ? 8'h00 : 8'(i)});
  endtask

  task automatic push_wr(input logic [31:0] lba);
    for (int i = 0; i < 512; i++)
      wr_q.push_back('{addr: {lba, 9'(i)}, data: ~8'(i)});
  endtask

  initial begin
    bit found;
    int cyc;
    bus.sd_lba = '0; bus.sd_rd = 1'b0; bus.sd_wr = 1'b0;
    clr();
    repeat (3) @(posedge clk_sys);
    #1;
    chk_outs_zero("rst");
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);

    // Plain read, in-range block.
    clr(); push_rd(5, 1'b0);
    run_req(1'b1, 1'b0, 32'd5, "rd5");
    chk("rd5_cnt", n_bwr, 512);
    chk("rd5_strd", n_strd, 512);
    chk("rd5_dbl", n_dbl, 0);
    chk("rd5_err", n_err, 0);
    chk("rd5_q", rd_q.size(), 0);

    // Plain write, block 2 -> store bytes 0x400..0x5FF.
    clr(); push_wr(32'd2);
    run_req(1'b0, 1'b1, 32'd2, "wr2");
    chk("wr2_cnt", n_stwr, 512);
    chk("wr2_bwr", n_bwr, 0);
    chk("wr2_q", wr_q.size(), 0);

    // Both levels high: read wins.
    clr(); push_rd(3, 1'b0);
    run_req(1'b1, 1'b1, 32'd3, "both");
    chk("both_stwr", n_stwr, 0);
    chk("both_bwr", n_bwr, 512);

    // Out-of-range read.
    clr(); push_rd(T_IMG_BLOCKS, 1'b1);
    run_req(1'b1, 1'b0, 32'(T_IMG_BLOCKS), "oobr");
    chk("oobr_err", n_err, 1);
    chk("oobr_strd", n_strd, 0);
    chk("oobr_bwr", n_bwr, 512);

    // Out-of-range write: data discarded.
    clr();
    run_req(1'b0, 1'b1, 32'd70000, "oobw");
    chk("oobw_err", n_err, 1);
    chk("oobw_stwr", n_stwr, 0);

    // Stalled store, read then write.
    stall_en = 1'b1;
    clr(); push_rd(9, 1'b0);
    run_req(1'b1, 1'b0, 32'd9, "strd");
    chk("strd_cnt", n_bwr, 512);
    chk("strd_dbl", n_dbl, 0);
    clr(); push_wr(32'd1);
    run_req(1'b0, 1'b1, 32'd1, "stwr");
    chk("stwr_cnt", n_stwr, 512);
    stall_en = 1'b0;

    // Reset at byte 100 of a read.
    clr(); push_rd(4, 1'b0);
    @(posedge clk_sys); #1;
    bus.sd_lba = 32'd4; bus.sd_rd = 1'b1;
    wait_ack("mid");
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 5000) begin
      @(negedge clk_sys);
      cyc++;
      if (bus.sd_buff_wr && bus.sd_buff_addr == 9'd100) found = 1'b1;
    end
    chk("mid_b100_seen", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs_zero("mid_rst");
    rd_q.delete();
    repeat (3) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("mid_wait_ack", bus.sd_ack, 0);
    chk("mid_wait_state", dut.r_state, ST_IDLE);
    clr(); push_rd(6, 1'b0);
    run_req(1'b1, 1'b0, 32'd6, "after");
    chk("after_cnt", n_bwr, 512);

    chk("both_high", n_both, 0);
    chk("unexpected", n_unexp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
